// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Brief    : Single-issue ALU with valid/ready handshake, one-cycle ALU ops
//             and a bit-serial shift-add multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module alu_pipe #(
   parameter int WIDTH = 16,
   parameter int SAT   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             ovfl,
   output logic             zero,
   output logic             neg,
   output logic             illegal
);

   localparam int               c_SHW  = $clog2(WIDTH);
   localparam logic [c_SHW-1:0] c_LAST = c_SHW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] c_SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] c_OP_ADD  = 3'b000;
   localparam logic [2:0] c_OP_SUB  = 3'b001;
   localparam logic [2:0] c_OP_NAND = 3'b010;
   localparam logic [2:0] c_OP_XOR  = 3'b011;
   localparam logic [2:0] c_OP_SLL  = 3'b100;
   localparam logic [2:0] c_OP_SRA  = 3'b101;
   localparam logic [2:0] c_OP_MUL  = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [c_SHW-1:0]     r_cnt;
   logic                 r_out_valid;
   logic [WIDTH-1:0]     r_result;
   logic                 r_ovfl;
   logic                 r_zero;
   logic                 r_neg;
   logic                 r_illegal;

   logic                 w_out_free;
   logic                 w_accept;
   logic [c_SHW-1:0]     w_shamt;
   logic [WIDTH-1:0]     w_sum;
   logic [WIDTH-1:0]     w_diff;
   logic [WIDTH-1:0]     w_alu_res;
   logic                 w_alu_ovfl;
   logic                 w_alu_ill;
   logic [2*WIDTH-1:0]   w_step_acc;
   logic                 w_step_last;

   assign w_out_free = !r_out_valid || out_ready;
   assign in_ready   = (r_state == S_IDLE) && w_out_free;
   assign w_accept   = in_valid && in_ready;

   assign w_shamt = b[c_SHW-1:0];
   assign w_sum   = a + b;
   assign w_diff  = a - b;

   always_comb begin
      w_alu_res  = '0;
      w_alu_ovfl = 1'b0;
      w_alu_ill  = 1'b0;
      case (op)
         c_OP_ADD: begin
            w_alu_res  = w_sum;
            w_alu_ovfl = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         c_OP_SUB: begin
            w_alu_res  = w_diff;
            w_alu_ovfl = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         c_OP_NAND: w_alu_res = ~(a & b);
         c_OP_XOR:  w_alu_res = a ^ b;
         c_OP_SLL:  w_alu_res = a << w_shamt;
         c_OP_SRA:  w_alu_res = $signed(a) >>> w_shamt;
         c_OP_MUL:  w_alu_res = '0;
         default:   w_alu_ill = 1'b1;
      endcase
      // Saturation direction follows the sign of a, the operand that overflowed away
      if ((SAT != 0) && w_alu_ovfl) begin
         w_alu_res = a[WIDTH-1] ? c_SMIN : c_SMAX;
      end
   end

   // One multiplier bit per cycle; the last step's sum is the full product
   assign w_step_acc  = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_step_last = (r_cnt == c_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_ovfl      <= 1'b0;
         r_zero      <= 1'b0;
         r_neg       <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (op == c_OP_MUL) begin
                     r_acc    <= '0;
                     r_mcand  <= {{WIDTH{1'b0}}, a};
                     r_mplier <= b;
                     r_cnt    <= '0;
                     r_state  <= S_MUL;
                  end else begin
                     r_out_valid <= 1'b1;
                     r_result    <= w_alu_res;
                     r_ovfl      <= w_alu_ovfl;
                     r_zero      <= (w_alu_res == '0);
                     r_neg       <= w_alu_res[WIDTH-1];
                     r_illegal   <= w_alu_ill;
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_step_acc;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (w_step_last) begin
                  r_cnt <= '0;
                  if (w_out_free) begin
                     r_out_valid <= 1'b1;
                     r_result    <= w_step_acc[WIDTH-1:0];
                     r_ovfl      <= |w_step_acc[2*WIDTH-1:WIDTH];
                     r_zero      <= (w_step_acc[WIDTH-1:0] == '0);
                     r_neg       <= w_step_acc[WIDTH-1];
                     r_illegal   <= 1'b0;
                     r_state     <= S_IDLE;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (w_out_free) begin
                  r_out_valid <= 1'b1;
                  r_result    <= r_acc[WIDTH-1:0];
                  r_ovfl      <= |r_acc[2*WIDTH-1:WIDTH];
                  r_zero      <= (r_acc[WIDTH-1:0] == '0);
                  r_neg       <= r_acc[WIDTH-1];
                  r_illegal   <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign ovfl      = r_ovfl;
   assign zero      = r_zero;
   assign neg       = r_neg;
   assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Brief    : Self-checking bench for alu_pipe (WIDTH=16, SAT=0 and SAT=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [2:0]  op;

   logic        in_ready, out_valid, ovfl, zero, neg, illegal;
   logic [15:0] result;
   logic        in_ready_s, out_valid_s, ovfl_s, zero_s, neg_s, illegal_s;
   logic [15:0] result_s;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(16), .SAT(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .ovfl(ovfl), .zero(zero), .neg(neg), .illegal(illegal)
   );

   alu_pipe #(.WIDTH(16), .SAT(1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .a(a), .b(b), .op(op), .out_valid(out_valid_s), .out_ready(out_ready),
      .result(result_s), .ovfl(ovfl_s), .zero(zero_s), .neg(neg_s), .illegal(illegal_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {ovfl, zero, neg, illegal, result} from integer arithmetic
   function automatic logic [19:0] model(input logic [2:0] o, input logic [15:0] x,
                                         input logic [15:0] y, input bit sat);
      int          sx, sy, s;
      logic [31:0] p;
      logic [15:0] r;
      logic        v, il;
      sx = int'($signed(x));
      sy = int'($signed(y));
      s = 0; p = '0; r = '0; v = 1'b0; il = 1'b0;
      case (o)
         3'd0: begin
            s = sx + sy; v = (s > 32767) || (s < -32768); r = s[15:0];
            if (sat && v) r = (sx >= 0) ? 16'h7FFF : 16'h8000;
         end
         3'd1: begin
            s = sx - sy; v = (s > 32767) || (s < -32768); r = s[15:0];
            if (sat && v) r = (sx >= 0) ? 16'h7FFF : 16'h8000;
         end
         3'd2: r = ~(x & y);
         3'd3: r = x ^ y;
         3'd4: r = x << y[3:0];
         3'd5: begin s = sx >>> y[3:0]; r = s[15:0]; end
         3'd6: begin p = {16'h0, x} * {16'h0, y}; r = p[15:0]; v = (p[31:16] != 16'h0); end
         default: il = 1'b1;
      endcase
      return {v, (r == 16'h0), r[15], il, r};
   endfunction

   task automatic check_out(input string tag, input logic [2:0] o,
                            input logic [15:0] x, input logic [15:0] y);
      logic [19:0] e0, e1;
      e0 = model(o, x, y, 1'b0);
      e1 = model(o, x, y, 1'b1);
      chk({tag, " res"},     result,                          e0[15:0]);
      chk({tag, " flags"},   {ovfl, zero, neg, illegal},      e0[19:16]);
      chk({tag, " res_s"},   result_s,                        e1[15:0]);
      chk({tag, " flags_s"}, {ovfl_s, zero_s, neg_s, illegal_s}, e1[19:16]);
   endtask

   // Issue one request, measure latency, check result, optionally hold it
   task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] x,
                         input logic [15:0] y, input int hold);
      int lat, guard;
      bit rdy_seen;
      @(negedge clk);
      out_ready = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, " accept"}, in_ready, 1);
      in_valid = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
      lat = 0;
      rdy_seen = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (!out_valid && in_ready) rdy_seen = 1'b1;
      end while (!out_valid && lat < 40);
      chk({tag, " latency"}, lat, (o == 3'd6) ? 17 : 1);
      if (o == 3'd6) chk({tag, " busy_ready"}, rdy_seen, 0);
      check_out(tag, o, x, y);
      if (hold > 0) begin
         out_ready = 1'b0;
         repeat (hold) @(negedge clk);
         chk({tag, " held_valid"}, out_valid, 1);
         chk({tag, " held_inready"}, in_ready, 0);
         check_out({tag, " held"}, o, x, y);
         out_ready = 1'b1;
      end
   endtask

   initial begin
      int lat, seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      repeat (2) @(negedge clk);
      chk("reset out_valid", {out_valid, out_valid_s}, 0);
      chk("reset result",    {result, result_s}, 0);
      chk("reset flags",     {ovfl, zero, neg, illegal, ovfl_s, zero_s, neg_s, illegal_s}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset in_ready", in_ready, 1);

      run_op("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 0);
      chk("add_ovf wrap",  {result, ovfl, neg},       {16'h8000, 1'b1, 1'b1});
      chk("add_ovf sat",   {result_s, ovfl_s, neg_s}, {16'h7FFF, 1'b1, 1'b0});
      run_op("sub_zero", 3'd1, 16'h0005, 16'h0005, 0);
      chk("sub_zero spec", {result, zero, ovfl}, {16'h0000, 1'b1, 1'b0});
      run_op("sub_ovf", 3'd1, 16'h8000, 16'h0001, 0);
      chk("sub_ovf spec", {result, ovfl}, {16'h7FFF, 1'b1});
      run_op("illegal", 3'd7, 16'h1234, 16'h4321, 0);
      chk("illegal spec", {result, illegal, zero}, {16'h0000, 1'b1, 1'b1});
      run_op("sra", 3'd5, 16'h8000, 16'h0013, 0);
      chk("sra spec", {result, neg, illegal}, {16'hF000, 1'b1, 1'b0});
      run_op("mul_hi", 3'd6, 16'h0100, 16'h0100, 0);
      chk("mul_hi spec", {result, ovfl, zero}, {16'h0000, 1'b1, 1'b1});
      run_op("mul_lo", 3'd6, 16'h00FF, 16'h0003, 0);
      chk("mul_lo spec", {result, ovfl}, {16'h02FD, 1'b0});

      // Backpressure on an XOR result, then back-to-back replacement by an ADD
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; op = 3'd3; a = 16'hF0F0; b = 16'h0FF0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp xor valid", out_valid, 1);
         chk("bp xor res", result, 16'hFF00);
         chk("bp xor inready", in_ready, 0);
      end
      in_valid = 1'b1; op = 3'd0; a = 16'h1234; b = 16'h1111; out_ready = 1'b1;
      #1 chk("bp release inready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("bp b2b valid", out_valid, 1);
      chk("bp b2b res", result, 16'h2345);

      // Release the ADD while accepting a MUL, then hold the MUL result
      out_ready = 1'b1; in_valid = 1'b1; op = 3'd6; a = 16'h00FF; b = 16'h0003;
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 40);
      chk("bp mul latency", lat, 17);
      repeat (3) begin
         @(negedge clk);
         chk("bp mul held", {out_valid, result, in_ready}, {1'b1, 16'h02FD, 1'b0});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 chk("bp mul drained", out_valid, 0);

      // Reset in the middle of a multiply
      @(negedge clk);
      in_valid = 1'b1; op = 3'd6; a = 16'h1234; b = 16'h5678;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort out_valid", out_valid, 0);
      chk("abort result", result, 0);
      chk("abort flags", {ovfl, zero, neg, illegal}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("abort inready", in_ready, 1);
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort no stale", seen, 0);

      // Randomized traffic with occasional backpressure
      for (int i = 0; i < 40; i++) begin
         run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 16'($urandom),
                16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
